sys_array_ctrl: RTL
===================

SYS_ARRAY_CTRL -- requirements
Module: sys_array_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter ARRAY_MAX_W, default 10, number of array columns (outputs).
REQ-003 SHALL have parameter ARRAY_MAX_L, default 10, number of array rows (input lanes).
REQ-004 SHALL have parameter MAX_ROWS, default 256, maximum input vectors per job.
REQ-005 SHALL have parameter OUT_LAT, default 3, cycles from lane-0 element on array_input to matching column-0 result on array_output.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  job request pulse, sampled in IDLE only.
REQ-009 SHALL have port num_rows  input  clog2(MAX_ROWS+1)  input vectors in the job, latched at start.
REQ-010 SHALL have port arr_len  input  clog2(ARRAY_MAX_L)  active length minus 1, latched at start.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-013 SHALL have port weights_load  output  1  weight-load strobe to the array.
REQ-014 SHALL have port array_w_l  output  clog2(ARRAY_MAX_L)  latched arr_len driven to the array.
REQ-015 SHALL have ports in_row_valid (input, 1), in_row_ready (output, 1) and in_row_data (input, ARRAY_MAX_L*DATA_WIDTH), forming the input-row stream.
REQ-016 SHALL have port array_input  output  ARRAY_MAX_L*DATA_WIDTH  skewed lanes to the array.
REQ-017 SHALL have port array_output  input  ARRAY_MAX_W*2*DATA_WIDTH  raw array results.
REQ-018 SHALL have ports out_valid (output, 1) and out_data (output, ARRAY_MAX_W*2*DATA_WIDTH), carrying result rows.

Function
REQ-019 SHALL implement states IDLE, LOAD, FEED, DRAIN and DONE.
REQ-020 SHALL, in IDLE, on start=1 at edge n, latch num_rows and arr_len and enter LOAD; weights_load=1 during cycle n+1 only.
REQ-021 SHALL go from LOAD to FEED, or directly to DONE when the latched num_rows=0.
REQ-022 SHALL, in FEED, drive in_row_ready=1 while rows remain; a row is accepted on an edge where valid and ready are both high.
REQ-023 SHALL drive lane k of array_input with element k of the row accepted at edge e during cycle e+1+k (diagonal skew, per-lane shift registers).
REQ-024 SHALL treat a FEED cycle without in_row_valid as a zero bubble: zeros are injected, the bubble is not counted, and no result is tagged.
REQ-025 SHALL carry a valid tag per accepted row through a shift pipeline; out_valid for the row accepted at edge e is asserted in cycle e+1+OUT_LAT+ARRAY_MAX_W-1.
REQ-026 SHALL delay column j of array_output by ARRAY_MAX_W-1-j cycles so that out_data presents a complete aligned result row; out_data=0 when out_valid=0.
REQ-027 SHALL enter DRAIN after the last row is accepted, feed zero lanes, and leave when the tag pipeline is empty.
REQ-028 SHALL go from DRAIN to DONE, pulse done=1 for one cycle, then return to IDLE.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL drive in_row_ready=0 outside FEED.

Reset
REQ-031 SHALL, on reset, enter IDLE and clear busy, done, weights_load, in_row_ready, out_valid, out_data, array_input, array_w_l, all skew/deskew registers and all tags.
REQ-032 SHALL, when reset is asserted mid-job, abandon the job and produce no out_valid or done afterwards.

Configuration
REQ-033 SHALL implement the deskew registers and the aligned out_valid timing of REQ-025/026 only when SYS_ARRAY_CTRL_DESKEW_EN is defined.
REQ-034 SHALL, when SYS_ARRAY_CTRL_DESKEW_EN is undefined, drive out_data=array_output unregistered, with out_valid asserted in cycle e+1+OUT_LAT (column-0 aligned).

Verification (DATA_WIDTH=8, ARRAY_MAX_W=10, ARRAY_MAX_L=10, OUT_LAT=3, macro defined unless noted)
REQ-035 SHALL check reset held 2 cycles -> all outputs 0, busy=0.
REQ-036 SHALL check start, num_rows=5, valid held high -> weights_load high one cycle, 5 ready cycles, row0 lane2 appears 2 cycles after row0 lane0, 5 consecutive out_valid pulses starting 13 cycles after row0 is accepted, then one done pulse.
REQ-037 SHALL check num_rows=5 with valid low for 2 cycles before row 2 -> zero lanes in the gap, out_valid pattern 11-00-111.
REQ-038 SHALL check start pulsed during FEED -> ignored, exactly one done; num_rows=0 -> done asserted 2 cycles after start, no ready.
REQ-039 SHALL check reset asserted during FEED -> next cycle busy=0, array_input=0, no later out_valid or done.
REQ-040 SHALL check macro undefined with num_rows=3 -> out_valid 4 cycles after each accepted row, out_data equal to array_output.

Source files
------------

// File: rtl/sys_array_ctrl.sv
// sys_array_ctrl: job sequencer for a systolic array. Loads weights, streams
// input rows onto diagonally skewed lanes, tags each accepted row, and
// presents the matching result rows on out_valid/out_data.
// Optional macro SYS_ARRAY_CTRL_DESKEW_EN: when defined, result columns are
// deskewed into one aligned row; otherwise out_data follows array_output
// directly with column-0 timing.
module sys_array_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ARRAY_MAX_W = 10,
    parameter int unsigned ARRAY_MAX_L = 10,
    parameter int unsigned MAX_ROWS    = 256,
    parameter int unsigned OUT_LAT     = 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]           num_rows,
    input  logic [$clog2(ARRAY_MAX_L)-1:0]          arr_len,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    weights_load,
    output logic [$clog2(ARRAY_MAX_L)-1:0]          array_w_l,
    input  logic                                    in_row_valid,
    output logic                                    in_row_ready,
    input  logic [ARRAY_MAX_L*DATA_WIDTH-1:0]       in_row_data,
    output logic [ARRAY_MAX_L*DATA_WIDTH-1:0]       array_input,
    input  logic [ARRAY_MAX_W*2*DATA_WIDTH-1:0]     array_output,
    output logic                                    out_valid,
    output logic [ARRAY_MAX_W*2*DATA_WIDTH-1:0]     out_data
);

    localparam int unsigned ROW_W = $clog2(MAX_ROWS + 1);
    localparam int unsigned RES_W = 2 * DATA_WIDTH;
`ifdef SYS_ARRAY_CTRL_DESKEW_EN
    localparam int unsigned TAG_D = OUT_LAT + ARRAY_MAX_W - 1;
`else
    localparam int unsigned TAG_D = OUT_LAT;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] rows_left;
    logic [TAG_D:0]   tags;
    logic             accept;

    assign accept = (state == S_FEED) && in_row_valid && in_row_ready;

    // Job sequencer: states, row countdown and all control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rows_left    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            weights_load <= 1'b0;
            in_row_ready <= 1'b0;
            array_w_l    <= '0;
        end else begin
            weights_load <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        rows_left    <= num_rows;
                        array_w_l    <= arr_len;
                        busy         <= 1'b1;
                        weights_load <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (rows_left == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state        <= S_FEED;
                        in_row_ready <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (accept) begin
                        rows_left <= rows_left - ROW_W'(1);
                        if (rows_left == ROW_W'(1)) begin
                            state        <= S_DRAIN;
                            in_row_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (tags == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Row tags: one bit per cycle, set only for accepted rows
    always_ff @(posedge clk) begin
        if (reset) tags <= '0;
        else       tags <= {tags[TAG_D-1:0], accept};
    end

    assign out_valid = tags[TAG_D];

    // Input skew: lane k runs through k+1 stages; bubbles and drain inject zeros
    for (genvar k = 0; k < ARRAY_MAX_L; k++) begin : g_skew
        logic [DATA_WIDTH-1:0] sr [k+1];

        // Per-lane shift chain
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int d = 0; d <= k; d++) sr[d] <= '0;
            end else begin
                sr[0] <= accept ? in_row_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int d = 1; d <= k; d++) sr[d] <= sr[d-1];
            end
        end

        assign array_input[k*DATA_WIDTH +: DATA_WIDTH] = sr[k];
    end

`ifdef SYS_ARRAY_CTRL_DESKEW_EN
    logic [ARRAY_MAX_W*RES_W-1:0] aligned;

    // Output deskew: column j waits ARRAY_MAX_W-1-j cycles for the last column
    for (genvar j = 0; j < ARRAY_MAX_W; j++) begin : g_deskew
        localparam int unsigned DLY = ARRAY_MAX_W - 1 - j;
        if (DLY == 0) begin : g_pass
            assign aligned[j*RES_W +: RES_W] = array_output[j*RES_W +: RES_W];
        end else begin : g_dly
            logic [RES_W-1:0] sr [DLY];

            // Per-column delay chain
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int d = 0; d < int'(DLY); d++) sr[d] <= '0;
                end else begin
                    sr[0] <= array_output[j*RES_W +: RES_W];
                    for (int d = 1; d < int'(DLY); d++) sr[d] <= sr[d-1];
                end
            end

            assign aligned[j*RES_W +: RES_W] = sr[DLY-1];
        end
    end

    assign out_data = out_valid ? aligned : '0;
`else
    assign out_data = out_valid ? array_output : '0;
`endif

endmodule
